// File: rtl/regfile_if.sv
// Register-file access bundle: one write port from WB, two read ports to ID.
interface regfile_if #(
    parameter int WIDTH = 64
);
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [4:0]       rd_addr1;
    logic [4:0]       rd_addr2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
        output rd_data1, rd_data2
    );
endinterface

// File: rtl/regfile.sv
// 32x64 ARM register file: X0-X30 in enabled registers, X31 (XZR) reads zero.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.

// One storage word with load enable and synchronous active-low clear.
module regfile_en_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Clear dominates load, so a write coinciding with reset is lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

module regfile #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
) (
    input  logic      clk,
    input  logic      reset,
    regfile_if.slave  bus
);
    localparam logic [4:0] XZR = 5'd31;

    logic [NREGS-1:0] wr_sel_s;
    logic [WIDTH-1:0] regs_s [NREGS];

    // Write-address decode: at most one enable, never for XZR.
    always_comb begin
        wr_sel_s = '0;
        if (bus.wr_en && (bus.wr_addr != XZR)) begin
            wr_sel_s[bus.wr_addr] = 1'b1;
        end else begin
            wr_sel_s = '0;
        end
    end

    for (genvar i = 0; i < NREGS - 1; i++) begin : g_reg
        regfile_en_reg #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (wr_sel_s[i]),
            .d     (bus.wr_data),
            .q     (regs_s[i])
        );
    end

    // XZR has no storage; the mux sees a constant zero in its slot.
    assign regs_s[NREGS-1] = '0;

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok_s;

    // Forwarding is only legal for a real, non-reset write to X0-X30.
    always_comb begin
        fwd_ok_s = bus.wr_en && reset && (bus.wr_addr != XZR);
    end

    // Read port 1 with forwarding of the in-flight write.
    always_comb begin
        bus.rd_data1 = regs_s[bus.rd_addr1];
        if (fwd_ok_s && (bus.rd_addr1 == bus.wr_addr)) begin
            bus.rd_data1 = bus.wr_data;
        end else begin
            bus.rd_data1 = regs_s[bus.rd_addr1];
        end
    end

    // Read port 2 with forwarding of the in-flight write.
    always_comb begin
        bus.rd_data2 = regs_s[bus.rd_addr2];
        if (fwd_ok_s && (bus.rd_addr2 == bus.wr_addr)) begin
            bus.rd_data2 = bus.wr_data;
        end else begin
            bus.rd_data2 = regs_s[bus.rd_addr2];
        end
    end
`else
    // Plain combinational read muxes; the hazard unit covers WB->ID.
    always_comb begin
        bus.rd_data1 = regs_s[bus.rd_addr1];
        bus.rd_data2 = regs_s[bus.rd_addr2];
    end
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus random traffic against an array model.
module tb_regfile;
    localparam int WIDTH = 64;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    logic [WIDTH-1:0] model [32];

    regfile_if #(.WIDTH(WIDTH)) bus ();

    regfile #(.WIDTH(WIDTH), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected read from the architectural rules: XZR zero, optional forwarding, else stored value.
    function automatic logic [WIDTH-1:0] ref_read(input logic [4:0] a);
        if (a == 5'd31) return '0;
        if (BYP && bus.wr_en && reset && (bus.wr_addr != 5'd31) && (a == bus.wr_addr))
            return bus.wr_data;
        return model[a];
    endfunction

    task automatic check_ports(input string tag);
        #1;
        check_eq({tag, "_rd1"}, bus.rd_data1, ref_read(bus.rd_addr1));
        check_eq({tag, "_rd2"}, bus.rd_data2, ref_read(bus.rd_addr2));
    endtask

    // Advance one edge, applying the spec's state rules to the model.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            for (int k = 0; k < 32; k++) model[k] = '0;
        end else if (bus.wr_en && (bus.wr_addr != 5'd31)) begin
            model[bus.wr_addr] = bus.wr_data;
        end
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [WIDTH-1:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr1 = 5'(i);
            bus.rd_addr2 = 5'(31 - i);
            check_ports($sformatf("%s_%0d", tag, i));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] hz_exp;
        n_checks = 0;
        n_pass = 0;
        for (int k = 0; k < 32; k++) model[k] = 'x;
        reset = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = 5'd0;
        bus.wr_data = '0;
        bus.rd_addr1 = 5'd0;
        bus.rd_addr2 = 5'd0;

        tick();
        tick();
        reset = 1'b1;
        sweep("reset");

        write_reg(5'd5, 64'h0123_4567_89AB_CDEF);
        write_reg(5'd30, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.rd_addr1 = 5'd5;
        bus.rd_addr2 = 5'd30;
        #1;
        check_eq("x5", bus.rd_data1, 64'h0123_4567_89AB_CDEF);
        check_eq("x30", bus.rd_data2, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.rd_addr1 = 5'd4;
        bus.rd_addr2 = 5'd6;
        #1;
        check_eq("x4_zero", bus.rd_data1, 64'h0);
        check_eq("x6_zero", bus.rd_data2, 64'h0);

        write_reg(5'd31, 64'h0000_0000_DEAD_BEEF);
        bus.rd_addr1 = 5'd31;
        bus.rd_addr2 = 5'd31;
        #1;
        check_eq("xzr_p1", bus.rd_data1, 64'h0);
        check_eq("xzr_p2", bus.rd_data2, 64'h0);
        sweep("xzr_sweep");

        bus.wr_en = 1'b0;
        bus.wr_addr = 5'd7;
        bus.wr_data = 64'h55;
        tick();
        tick();
        tick();
        bus.rd_addr1 = 5'd7;
        #1;
        check_eq("x7_wen_low", bus.rd_data1, 64'h0);

        write_reg(5'd9, 64'h11);
        bus.wr_en = 1'b1;
        bus.wr_addr = 5'd9;
        bus.wr_data = 64'h22;
        bus.rd_addr1 = 5'd9;
        bus.rd_addr2 = 5'd9;
        hz_exp = BYP ? 64'h22 : 64'h11;
        #1;
        check_eq("hazard_pre", bus.rd_data1, hz_exp);
        check_eq("hazard_pre_p2", bus.rd_data2, hz_exp);
        tick();
        bus.wr_en = 1'b0;
        #1;
        check_eq("hazard_post", bus.rd_data1, 64'h22);

        write_reg(5'd3, 64'hAA);
        reset = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 64'hBB;
        bus.rd_addr1 = 5'd3;
        #1;
        check_eq("rst_no_bypass", bus.rd_data1, 64'hAA);
        tick();
        reset = 1'b1;
        bus.wr_en = 1'b0;
        #1;
        check_eq("rst_beats_write", bus.rd_data1, 64'h0);

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 31) != 0);
            bus.wr_en = ($urandom_range(0, 3) != 0);
            bus.wr_addr = 5'($urandom_range(0, 31));
            bus.wr_data = {$urandom(), $urandom()};
            bus.rd_addr1 = ($urandom_range(0, 3) == 0) ? bus.wr_addr : 5'($urandom_range(0, 31));
            bus.rd_addr2 = 5'($urandom_range(0, 31));
            check_ports($sformatf("rnd_pre_%0d", n));
            tick();
            check_ports($sformatf("rnd_post_%0d", n));
        end

        bus.wr_en = 1'b0;
        reset = 1'b1;
        sweep("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile.md
# regfile

32-entry × 64-bit architectural register file for the pipelined ARM datapath. It is the storage array built from 31 instances of the 64-bit enabled register, plus the write-address decode and two read-port muxes. It sits between the ID stage, which reads operands, and the WB stage, which writes results. X31 (XZR) is hardwired to zero.

## Interface
Parameters:
- WIDTH, 64, data width of each register.
- NREGS, 32, number of architectural registers. Fixed; the address is 5 bits.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low. 0 at a rising clk edge clears all registers.
- wr_en  input  1  write enable from WB.
- wr_addr  input  5  destination register index.
- wr_data  input  WIDTH  write data.
- rd_addr1  input  5  read port 1 index (Rn).
- rd_addr2  input  5  read port 2 index (Rm/Rt).
- rd_data1  output  WIDTH  read port 1 data.
- rd_data2  output  WIDTH  read port 2 data.

## Operation
- Storage: registers X0–X30 are built from 31 enabled registers. X31 has no storage.
- Write decode: a 5→32 decoder gated by wr_en drives the per-register enable. Exactly one enable is high when wr_en=1 and wr_addr≠31. No enable is high otherwise.
- Write to X31 is discarded; no state changes.
- Reads are combinational:
  - rd_dataN = contents of X[rd_addrN].
  - rd_addrN=31 → rd_dataN = 0, always, including under bypass.
- Both ports may address the same register; both return identical data.
- Reset (reset=0 at an edge) clears X0–X30 to 0. Reset has priority over any write in the same cycle; that write is lost.
- With reset held at 0, the clearing repeats every edge and writes are ignored.
- Outputs have no registers of their own. After reset, every read returns 0.

## Timing
- Write latency: wr_data is captured at the rising edge where wr_en=1 and reset=1. It is visible on the read ports immediately after that edge.
- Read latency: 0 cycles, combinational from rd_addrN and storage.
- Same-cycle write/read of the same register (not X31): behaviour depends on the Configuration macro.
- Reset mid-stream: registers read 0 from the edge where reset=0 is sampled. Until that edge, the prior contents remain visible.
- Back-to-back writes to one register: the last write before an edge wins. Each edge captures exactly one value.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: internal write-to-read forwarding is compiled in.
  - If wr_en=1, wr_addr≠31, reset=1 and rd_addrN==wr_addr, then rd_dataN = wr_data combinationally in the same cycle.
  - This removes the WB→ID hazard without a separate forwarding path.
- Undefined: no forwarding. rd_dataN shows the old register value until the edge, and the hazard unit must stall one cycle.
- In both modes:
  - X31 reads 0.
  - When reset=0, the bypass is suppressed and reads return stored values.

## Test plan
- Reset: hold reset=0 for 2 edges, then sweep rd_addr1/rd_addr2 over 0..31 → all reads are 0.
- Write/readback:
  - Write X5=64'h0123_4567_89AB_CDEF and X30=64'hFFFF_FFFF_FFFF_FFFF on consecutive edges.
  - After the edges, rd_addr1=5 / rd_addr2=30 → those exact values.
  - X4 and X6 are still 0.
- XZR: wr_en=1, wr_addr=31, wr_data=64'hDEAD_BEEF, then read 31 on both ports → 0. A full sweep shows no other register changed.
- Enable low: wr_en=0, wr_addr=7, wr_data=64'h55 for 3 edges → X7 unchanged (0).
- Same-cycle hazard: X9 holds 64'h11. Write 64'h22 to X9 with rd_addr1=9 before the edge.
  - With REGFILE_BYPASS_EN: rd_data1=64'h22 before the edge.
  - Without it: rd_data1=64'h11 before the edge.
  - Both modes: 64'h22 after the edge.
- Reset vs write: X3=64'hAA. Assert reset=0 in the same cycle as wr_en=1, wr_addr=3, wr_data=64'hBB → X3=0 after the edge, not 64'hBB.
